// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: turns a spike line into a per-window spike count and the inter-spike interval.
module spike_rate_decoder #(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = 8,
  parameter int ISI_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [COUNT_W-1:0]  rate_out,
  output logic                rate_valid,
  output logic                rate_sat,
  output logic [ISI_W-1:0]    isi_out,
  output logic                isi_valid
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state_q;
  logic spk_q, sat_q, sat_d, have_prev_q, ev, win_end;
  logic [WINDOW_W-1:0] win_q, tick_q;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [ISI_W-1:0] ivl_q, ivl_d;
  always_comb begin
    ev = spike_in & ~spk_q & en & (state_q == COUNT);
    cnt_d = (ev && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    sat_d = sat_q | (ev & (&cnt_q));
    ivl_d = ev ? ISI_W'(1) : (&ivl_q) ? ivl_q : ivl_q + 1'b1;
    win_end = tick_q == win_q - 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      spk_q <= 1'b0;
      sat_q <= 1'b0;
      have_prev_q <= 1'b0;
      win_q <= '0;
      tick_q <= '0;
      cnt_q <= '0;
      ivl_q <= '0;
      rate_out <= '0;
      rate_valid <= 1'b0;
      rate_sat <= 1'b0;
      isi_out <= '0;
      isi_valid <= 1'b0;
    end else begin
      spk_q <= spike_in;
      rate_valid <= 1'b0;
      isi_valid <= 1'b0;
      if (state_q == IDLE) begin
        have_prev_q <= 1'b0;
        if (en && window_len != '0) begin
          state_q <= COUNT;
          win_q <= window_len;
          tick_q <= '0;
          cnt_q <= '0;
          sat_q <= 1'b0;
          ivl_q <= '0;
        end
      end else if (!en) begin
        state_q <= IDLE;
        have_prev_q <= 1'b0;
      end else begin
        ivl_q <= ivl_d;
        have_prev_q <= have_prev_q | ev;
        if (ev && have_prev_q) begin
          isi_out <= ivl_q;
          isi_valid <= 1'b1;
        end
        // the closing edge's own event belongs to the window being reported
        if (win_end) begin
          rate_out <= cnt_d;
          rate_sat <= sat_d;
          rate_valid <= 1'b1;
          tick_q <= '0;
          cnt_q <= '0;
          sat_q <= 1'b0;
          win_q <= window_len;
          if (window_len == '0) state_q <= IDLE;
        end else begin
          tick_q <= tick_q + 1'b1;
          cnt_q <= cnt_d;
          sat_q <= sat_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: scoreboard bench; expected reports are queued, a negedge monitor checks them.
module tb_spike_rate_decoder;
  localparam int CW = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, spike_in = 1'b0;
  logic [7:0] window_len = '0;
  logic [CW-1:0] rate_out;
  logic rate_valid, rate_sat, isi_valid;
  logic [7:0] isi_out;
  int total = 0, passed = 0;
  int rq[$], sq[$], iq[$];

  spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(CW), .ISI_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .window_len(window_len),
    .rate_out(rate_out), .rate_valid(rate_valid), .rate_sat(rate_sat),
    .isi_out(isi_out), .isi_valid(isi_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) if (!rst) begin
    if (rate_valid) begin
      if (rq.size() == 0) begin
        total++;
        $display("FAIL rate_unexpected got rate=%0d expected no report at %0t", rate_out, $time);
      end else begin
        chk("rate_out", int'(rate_out), rq.pop_front());
        chk("rate_sat", int'(rate_sat), sq.pop_front());
      end
    end
    if (isi_valid) begin
      if (iq.size() == 0) begin
        total++;
        $display("FAIL isi_unexpected got isi=%0d expected no report at %0t", isi_out, $time);
      end else chk("isi_out", int'(isi_out), iq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rate(input int r, input int s);
    rq.push_back(r);
    sq.push_back(s);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((rq.size() != 0 || iq.size() != 0) && n < 20) begin
      step();
      n++;
    end
    if (rq.size() != 0 || iq.size() != 0) begin
      total++;
      $display("FAIL %s_drain got pending rate=%0d isi=%0d expected 0", name, rq.size(), iq.size());
      rq.delete();
      sq.delete();
      iq.delete();
    end
  endtask

  // start edge, then counting edges 1..n; spike_in high at first, first+per, ... up to last
  task automatic run(input int w, input int n, input int first, input int per, input int last);
    en = 1'b1;
    window_len = 8'(w);
    spike_in = 1'b0;
    step();
    for (int k = 1; k <= n; k++) begin
      spike_in = (k >= first && k <= last && (k - first) % per == 0);
      step();
    end
    en = 1'b0;
    spike_in = 1'b0;
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom);
      spike_in = 1'($urandom);
      window_len = 8'($urandom);
      step();
      chk("rst_outputs", int'({rate_out, rate_valid, rate_sat, isi_out, isi_valid}), 0);
    end
    en = 1'b0;
    spike_in = 1'b0;
    window_len = 8'd10;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("idle_outputs", int'({rate_out, rate_valid, rate_sat, isi_out, isi_valid}), 0);

    // steady: spikes at counting edges 1,4,..,28 over three 10-edge windows
    push_rate(4, 0); push_rate(3, 0); push_rate(3, 0);
    for (int i = 0; i < 9; i++) iq.push_back(3);
    run(10, 30, 1, 3, 28);
    drain("steady");

    // abort at counting edge 5 after spikes at 1 and 3
    iq.push_back(2);
    run(10, 4, 1, 2, 3);
    drain("abort");
    chk("abort_rate_held", int'(rate_out), 3);
    chk("abort_sat_held", int'(rate_sat), 0);
    push_rate(2, 0);
    iq.push_back(3);
    run(10, 10, 2, 3, 5);
    drain("restart");

    // held spike: high from counting edge 2 through 21
    push_rate(1, 0); push_rate(0, 0); push_rate(0, 0);
    run(8, 24, 2, 1, 21);
    drain("held");

    // saturation: 20 events in a 40-edge window, then a quiet window
    push_rate(15, 1); push_rate(0, 0);
    for (int i = 0; i < 19; i++) iq.push_back(2);
    run(40, 80, 1, 2, 39);
    drain("saturation");

    // interval of 300 edges saturates the 8-bit interval counter
    push_rate(1, 0); push_rate(0, 0); push_rate(0, 0);
    iq.push_back(255);
    run(100, 301, 1, 300, 301);
    drain("isi_sat");

    // window length 1: a report every edge
    for (int i = 0; i < 4; i++) begin
      push_rate(1, 0);
      push_rate(0, 0);
    end
    for (int i = 0; i < 3; i++) iq.push_back(2);
    run(1, 8, 1, 2, 7);
    drain("len1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
